// File: rtl/st_shifter_core.sv
// rtl/st_shifter_core.sv - bitplane shifter with palette lookup and register port
module st_shifter_core #(
    parameter int PLANES_MAX = 4,
    parameter int COLOR_BITS = 4,
    parameter int WORD_BITS  = 16
) (
    input  logic                  CLOCK_32,
    input  logic                  RESET_N,
    input  logic                  de,
    input  logic                  load,
    input  logic                  cs,
    input  logic                  rw,
    input  logic [4:0]            addr,
    input  logic [WORD_BITS-1:0]  data_in,
    output logic [WORD_BITS-1:0]  data_out,
    output logic                  oe,
    output logic                  pix_strobe,
    output logic [COLOR_BITS-1:0] r,
    output logic [COLOR_BITS-1:0] g,
    output logic [COLOR_BITS-1:0] b
);

    localparam int PAL_N      = 1 << PLANES_MAX;
    localparam int ENT_W      = 3 * COLOR_BITS;
    localparam int WC_W       = $clog2(PLANES_MAX + 1);
    localparam int PC_W       = $clog2(WORD_BITS);
    localparam int MED_PLANES = (PLANES_MAX / 2 < 1) ? 1 : PLANES_MAX / 2;

    logic [ENT_W-1:0]      pal_q [PAL_N];
    logic [ENT_W-1:0]      pal_d [PAL_N];
    logic [WORD_BITS-1:0]  lat_q [PLANES_MAX];
    logic [WORD_BITS-1:0]  lat_d [PLANES_MAX];
    logic [WORD_BITS-1:0]  sh_q  [PLANES_MAX];
    logic [WORD_BITS-1:0]  sh_d  [PLANES_MAX];
    logic [1:0]            mode_q, mode_d;
    logic                  ovf_q, ovf_d;
    logic [1:0]            div_q, div_d;
    logic [PC_W-1:0]       pc_q, pc_d;
    logic [WC_W-1:0]       wc_q, wc_d;
    logic [COLOR_BITS-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
    logic [WORD_BITS-1:0]  dout_q, dout_d;
    logic                  oe_q, oe_d;

    logic [WC_W-1:0]       planes;
    logic [1:0]            div_last;
    logic                  tick, xfer, wr_en, rd_en, pal_hit, mode_wr, resync, v;
    logic [PLANES_MAX-1:0] idx;
    logic [ENT_W-1:0]      ent;

    always_comb begin
        case (mode_q)
            2'd0:    begin planes = WC_W'(PLANES_MAX); div_last = 2'd3; end
            2'd1:    begin planes = WC_W'(MED_PLANES); div_last = 2'd1; end
            default: begin planes = WC_W'(1);          div_last = 2'd0; end
        endcase
    end

    assign tick    = (div_q == div_last);
    assign xfer    = tick && (pc_q == PC_W'(WORD_BITS - 1));
    assign wr_en   = cs && !rw;
    assign rd_en   = cs && rw;
    assign pal_hit = (addr < 5'(PAL_N));
    assign mode_wr = wr_en && (addr == 5'h10);
    assign resync  = mode_wr && (data_in[1:0] != mode_q);

    // Planes beyond the active count never contribute to the index.
    always_comb begin
        idx = '0;
        for (int p = 0; p < PLANES_MAX; p++) begin
            idx[p] = (WC_W'(p) < planes) && sh_q[p][WORD_BITS-1];
        end
    end

    assign ent = pal_q[idx];
    assign v   = idx[0] ^ pal_q[0][0];

    always_comb begin
        pal_d  = pal_q;
        lat_d  = lat_q;
        sh_d   = sh_q;
        mode_d = mode_q;
        ovf_d  = ovf_q;
        div_d  = div_q + 2'd1;
        pc_d   = pc_q;
        wc_d   = wc_q;
        r_d    = r_q;
        g_d    = g_q;
        b_d    = b_q;
        oe_d   = rd_en;
        dout_d = '0;

        if (tick) begin
            div_d = '0;
            pc_d  = xfer ? '0 : pc_q + 1'b1;
            if (!de) begin
                r_d = '0;
                g_d = '0;
                b_d = '0;
            end else if (mode_q[1]) begin
                r_d = {COLOR_BITS{v}};
                g_d = {COLOR_BITS{v}};
                b_d = {COLOR_BITS{v}};
            end else begin
                r_d = ent[3*COLOR_BITS-1:2*COLOR_BITS];
                g_d = ent[2*COLOR_BITS-1:COLOR_BITS];
                b_d = ent[COLOR_BITS-1:0];
            end
            for (int p = 0; p < PLANES_MAX; p++) begin
                sh_d[p] = {sh_q[p][WORD_BITS-2:0], 1'b0};
            end
            // An incomplete group is discarded in favour of a blank line of colour 0.
            if (xfer) begin
                for (int p = 0; p < PLANES_MAX; p++) begin
                    sh_d[p] = ((wc_q == planes) && (WC_W'(p) < planes)) ? lat_q[p] : '0;
                end
                if (wc_q == planes) begin
                    wc_d = '0;
                end
            end
        end

        if (resync) begin
            div_d = '0;
            pc_d  = '0;
            wc_d  = '0;
            for (int p = 0; p < PLANES_MAX; p++) begin
                sh_d[p] = '0;
            end
        end

        if (mode_wr) begin
            mode_d = data_in[1:0];
            ovf_d  = 1'b0;
        end

        if (wr_en && pal_hit) begin
            pal_d[addr[PLANES_MAX-1:0]] = data_in[ENT_W-1:0];
        end

        // wc_d already reflects a same-edge transfer or resync.
        if (load) begin
            if (wc_d < planes) begin
                for (int p = 0; p < PLANES_MAX; p++) begin
                    if (WC_W'(p) == wc_d) begin
                        lat_d[p] = data_in;
                    end
                end
                wc_d = wc_d + 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end

        if (rd_en) begin
            if (pal_hit) begin
                dout_d = WORD_BITS'(pal_q[addr[PLANES_MAX-1:0]]);
            end else if (addr == 5'h10) begin
                dout_d = WORD_BITS'({ovf_q, 5'b0, mode_q});
            end
        end
    end

    always_ff @(posedge CLOCK_32 or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < PAL_N; i++) begin
                pal_q[i] <= '0;
            end
            for (int p = 0; p < PLANES_MAX; p++) begin
                lat_q[p] <= '0;
                sh_q[p]  <= '0;
            end
            mode_q <= '0;
            ovf_q  <= 1'b0;
            div_q  <= '0;
            pc_q   <= '0;
            wc_q   <= '0;
            r_q    <= '0;
            g_q    <= '0;
            b_q    <= '0;
            dout_q <= '0;
            oe_q   <= 1'b0;
        end else begin
            pal_q  <= pal_d;
            lat_q  <= lat_d;
            sh_q   <= sh_d;
            mode_q <= mode_d;
            ovf_q  <= ovf_d;
            div_q  <= div_d;
            pc_q   <= pc_d;
            wc_q   <= wc_d;
            r_q    <= r_d;
            g_q    <= g_d;
            b_q    <= b_d;
            dout_q <= dout_d;
            oe_q   <= oe_d;
        end
    end

    assign data_out   = dout_q;
    assign oe         = oe_q;
    assign pix_strobe = tick;
    assign r          = r_q;
    assign g          = g_q;
    assign b          = b_q;

endmodule

// File: tb/tb_st_shifter_core.sv
// tb/tb_st_shifter_core.sv - register vectors plus pixel scoreboard for st_shifter_core
module tb_st_shifter_core;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        de = 1'b1;
    logic        load = 1'b0;
    logic        cs = 1'b0;
    logic        rw = 1'b0;
    logic [4:0]  addr = '0;
    logic [15:0] data_in = '0;
    logic [15:0] data_out;
    logic        oe;
    logic        pix_strobe;
    logic [3:0]  r, g, b;

    int          n_checks = 0;
    int          n_pass = 0;
    logic [11:0] sb[$];
    logic [11:0] mon_exp;

    typedef struct {
        logic        wr;
        logic [4:0]  a;
        logic [15:0] wdata;
        logic [15:0] exp;
    } reg_vec_t;

    reg_vec_t vecs[11];

    st_shifter_core #(.PLANES_MAX(4), .COLOR_BITS(4), .WORD_BITS(16)) dut (
        .CLOCK_32  (clk),
        .RESET_N   (rst_n),
        .de        (de),
        .load      (load),
        .cs        (cs),
        .rw        (rw),
        .addr      (addr),
        .data_in   (data_in),
        .data_out  (data_out),
        .oe        (oe),
        .pix_strobe(pix_strobe),
        .r         (r),
        .g         (g),
        .b         (b)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Each tick edge registers one pixel; compare it against the next expected colour.
    always @(negedge clk) begin
        if (rst_n && pix_strobe) begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                mon_exp = sb.pop_front();
                check("pixel", {20'b0, r, g, b}, {20'b0, mon_exp});
            end
        end
    end

    task automatic push_n(input int n, input logic [11:0] v);
        for (int i = 0; i < n; i++) sb.push_back(v);
    endtask

    task automatic push_alt(input logic [11:0] first, input logic [11:0] second);
        for (int i = 0; i < 16; i++) sb.push_back((i % 2 == 0) ? first : second);
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [15:0] d);
        cs = 1'b1; rw = 1'b0; addr = a; data_in = d;
        @(posedge clk); #1;
        cs = 1'b0;
    endtask

    task automatic read_check(input string name, input logic [4:0] a, input logic [15:0] exp);
        cs = 1'b1; rw = 1'b1; addr = a;
        @(posedge clk); #1;
        cs = 1'b0; rw = 1'b0;
        check({name, "_oe"}, {31'b0, oe}, 32'd1);
        check({name, "_data"}, {16'b0, data_out}, {16'b0, exp});
        @(posedge clk); #1;
        check({name, "_oe_low"}, {31'b0, oe}, 32'd0);
    endtask

    task automatic load_word(input logic [15:0] d);
        load = 1'b1; data_in = d;
        @(posedge clk); #1;
        load = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clk);
        check("drain", sb.size(), 32'd0);
        sb.delete();
    endtask

    task automatic measure_period(input int exp);
        int n;
        logic found;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (pix_strobe) found = 1'b1;
        end
        n = 0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            n++;
            if (pix_strobe) found = 1'b1;
        end
        check("strobe_period", n, exp);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 5'd5,    16'h0A53, 16'h0000};
        vecs[1]  = '{1'b0, 5'd5,    16'h0000, 16'h0A53};
        vecs[2]  = '{1'b0, 5'h1F,   16'h0000, 16'h0000};
        vecs[3]  = '{1'b1, 5'h11,   16'h1234, 16'h0000};
        vecs[4]  = '{1'b0, 5'h11,   16'h0000, 16'h0000};
        vecs[5]  = '{1'b1, 5'd3,    16'hFABC, 16'h0000};
        vecs[6]  = '{1'b0, 5'd3,    16'h0000, 16'h0ABC};
        vecs[7]  = '{1'b1, 5'd15,   16'h0FFF, 16'h0000};
        vecs[8]  = '{1'b0, 5'd15,   16'h0000, 16'h0FFF};
        vecs[9]  = '{1'b0, 5'h10,   16'h0000, 16'h0000};
        vecs[10] = '{1'b0, 5'd4,    16'h0000, 16'h0000};

        repeat (3) @(posedge clk);
        #1;
        check("rst_data_out", {16'b0, data_out}, 32'd0);
        check("rst_oe", {31'b0, oe}, 32'd0);
        check("rst_strobe", {31'b0, pix_strobe}, 32'd0);
        check("rst_rgb", {20'b0, r, g, b}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            if (vecs[i].wr) write_reg(vecs[i].a, vecs[i].wdata);
            else read_check("reg", vecs[i].a, vecs[i].exp);
        end

        // Low res: index 5 for one group, each pixel four cycles wide
        for (int i = 0; i < 16; i++) write_reg(5'(i), 16'(i * 16'h111));
        write_reg(5'h10, 16'h0001);
        write_reg(5'h10, 16'h0000);
        @(negedge clk);
        push_n(16, 12'h000);
        push_n(16, 12'h555);
        push_n(4, 12'h000);
        load_word(16'hFFFF);
        load_word(16'h0000);
        load_word(16'hFFFF);
        load_word(16'h0000);
        measure_period(4);
        wait_drain(800);

        // High res: alternating pixels every cycle, then inverted via palette[0] bit 0
        write_reg(5'd0, 16'h0000);
        write_reg(5'h10, 16'h0002);
        @(negedge clk);
        push_n(16, 12'h000);
        push_alt(12'hFFF, 12'h000);
        push_n(4, 12'h000);
        load_word(16'hAAAA);
        measure_period(1);
        wait_drain(200);

        write_reg(5'd0, 16'h0001);
        write_reg(5'h10, 16'h0003);
        @(negedge clk);
        push_n(16, 12'hFFF);
        push_alt(12'h000, 12'hFFF);
        push_n(4, 12'hFFF);
        load_word(16'hAAAA);
        wait_drain(200);

        // Medium: third load is dropped, overflow is sticky until a mode write
        write_reg(5'd0, 16'h0000);
        write_reg(5'h10, 16'h0001);
        @(negedge clk);
        push_n(16, 12'h000);
        push_n(16, 12'h111);
        push_n(4, 12'h000);
        load_word(16'hFFFF);
        load_word(16'h0000);
        load_word(16'hFFFF);
        read_check("mode_ovf", 5'h10, 16'h0081);
        write_reg(5'h10, 16'h0001);
        read_check("mode_clr", 5'h10, 16'h0001);
        wait_drain(400);

        // Blanking for the first seven ticks, then a load on the transfer edge
        write_reg(5'd0, 16'h00F0);
        de = 1'b0;
        write_reg(5'h10, 16'h0000);
        @(negedge clk);
        push_n(7, 12'h000);
        push_n(9, 12'h0F0);
        push_n(16, 12'h111);
        push_n(16, 12'h222);
        push_n(4, 12'h0F0);
        load_word(16'hFFFF);
        load_word(16'h0000);
        load_word(16'h0000);
        load_word(16'h0000);
        repeat (26) @(posedge clk);
        #1;
        de = 1'b1;
        repeat (33) @(posedge clk);
        #1;
        load_word(16'h0000);
        load_word(16'hFFFF);
        load_word(16'h0000);
        load_word(16'h0000);
        wait_drain(800);

        // Asynchronous reset while a read result is on the bus
        cs = 1'b1; rw = 1'b1; addr = 5'd5;
        @(posedge clk); #1;
        cs = 1'b0; rw = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_data_out", {16'b0, data_out}, 32'd0);
        check("arst_oe", {31'b0, oe}, 32'd0);
        check("arst_rgb", {20'b0, r, g, b}, 32'd0);
        check("arst_strobe", {31'b0, pix_strobe}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        read_check("post_rst_mode", 5'h10, 16'h0000);
        read_check("post_rst_pal", 5'd5, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
